// File: rtl/uart_tx_framed.sv
// uart_tx_framed: FIFO-buffered UART transmitter with
// configurable data width, parity mode and stop-bit count.
module uart_tx_framed #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_END = TW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic          ODD      = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 ready_q;
  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        wr_q, rd_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head;
  logic                 push, pop;

  assign push       = data_valid && ready_q;
  assign head       = mem_q[rd_q];
  assign data_ready = ready_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = ^head ^ ODD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PAR: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == STOP_END) begin
          cnt_d = '0;
          // chain straight into the next start bit when data is waiting
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = ^head ^ ODD;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs are decoded from next state so they can be registered
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      S_PAR:   txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ready_q <= (count_d != FULL);
      count_q <= count_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data_in;
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// tb_uart_tx_framed: directed bench for uart_tx_framed using
// three configurations and a frame-decoding scoreboard.
module tb_uart_tx_framed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a: 8 data bits, even parity, 1 stop
  logic       rst_a, dv_a, rdy_a, txd_a, busy_a;
  logic [7:0] din_a;
  logic [2:0] cnt_a;
  // dut_b: 7 data bits, odd parity, 2 stop
  logic       rst_b, dv_b, rdy_b, txd_b, busy_b;
  logic [6:0] din_b;
  logic [2:0] cnt_b;
  // dut_c: 8 data bits, no parity, 1 stop
  logic       rst_c, dv_c, rdy_c, txd_c, busy_c;
  logic [7:0] din_c;
  logic [2:0] cnt_c;

  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .data_in(din_a), .data_valid(dv_a),
    .data_ready(rdy_a), .txd(txd_a), .busy(busy_a), .fifo_count(cnt_a));

  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .data_in(din_b), .data_valid(dv_b),
    .data_ready(rdy_b), .txd(txd_b), .busy(busy_b), .fifo_count(cnt_b));

  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst_c), .data_in(din_c), .data_valid(dv_c),
    .data_ready(rdy_c), .txd(txd_c), .busy(busy_c), .fifo_count(cnt_c));

  logic [7:0]  sb[$];
  int unsigned starts[$];
  bit          abort_c = 1'b0;
  int          busy_cnt_a = 0;
  int          busy_cnt_b = 0;
  int          busy_cnt_c = 0;

  always @(negedge clk) if (busy_a === 1'b1) busy_cnt_a++;
  always @(negedge clk) if (busy_b === 1'b1) busy_cnt_b++;
  always @(negedge clk) if (busy_c === 1'b1) busy_cnt_c++;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // receiver for dut_c: samples each bit mid-period
  initial begin : mon_c
    logic [7:0] w;
    logic       st, sp;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (txd_c === 1'b0) begin
        starts.push_back(cyc);
        repeat (2) @(negedge clk);
        st = txd_c;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          w[i] = txd_c;
        end
        repeat (4) @(negedge clk);
        sp = txd_c;
        if (abort_c) begin
          abort_c = 1'b0;
        end else begin
          check("mon_start_bit", {31'd0, st}, 32'd0);
          check("mon_stop_bit", {31'd0, sp}, 32'd1);
          check("mon_frame_expected", sb.size() != 0, 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("mon_word", {24'd0, w}, {24'd0, e});
          end
        end
      end
    end
  end

  task automatic push_c(input logic [7:0] w);
    din_c = w;
    dv_c  = 1'b1;
    check("push_ready", {31'd0, rdy_c}, 32'd1);
    sb.push_back(w);
    @(negedge clk);
    dv_c = 1'b0;
  endtask

  task automatic wait_idle_c(input int limit);
    int n = 0;
    while (!(busy_c === 1'b0 && cnt_c === 3'd0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < limit, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [10:0] seq_a;
    logic [10:0] seq_b;
    logic [7:0]  wa;
    logic [6:0]  wb;
    logic [7:0]  val;
    logic [2:0]  prev, maxc;
    logic        rdy, noisy;
    int          pops, nstart;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    check("rst_txd_a", {31'd0, txd_a}, 32'd1);
    check("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("rst_cnt_a", {29'd0, cnt_a}, 32'd0);
    check("rst_rdy_a", {31'd0, rdy_a}, 32'd1);
    check("rst_txd_b", {31'd0, txd_b}, 32'd1);
    check("rst_busy_b", {31'd0, busy_b}, 32'd0);
    check("rst_txd_c", {31'd0, txd_c}, 32'd1);
    check("rst_cnt_c", {29'd0, cnt_c}, 32'd0);
    check("rst_rdy_c", {31'd0, rdy_c}, 32'd1);

    // 1: even parity frame of 0xA5
    wa = 8'hA5;
    seq_a[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq_a[i+1] = wa[i];
    seq_a[9]  = ^wa;
    seq_a[10] = 1'b1;
    busy_cnt_a = 0;
    din_a = wa; dv_a = 1'b1;
    @(negedge clk);
    dv_a = 1'b0;
    check("t1_cnt_after_push", {29'd0, cnt_a}, 32'd1);
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (k == 0) check("t1_cnt_after_pop", {29'd0, cnt_a}, 32'd0);
      check("t1_txd", {31'd0, txd_a}, {31'd0, seq_a[k/4]});
      check("t1_busy", {31'd0, busy_a}, 32'd1);
    end
    @(negedge clk);
    check("t1_idle_busy", {31'd0, busy_a}, 32'd0);
    check("t1_idle_txd", {31'd0, txd_a}, 32'd1);
    check("t1_busy_len", busy_cnt_a, 32'd44);

    // 2: odd parity, 7 bits, two stop bits
    wb = 7'h01;
    seq_b[0] = 1'b0;
    for (int i = 0; i < 7; i++) seq_b[i+1] = wb[i];
    seq_b[8]  = ~(^wb);
    seq_b[9]  = 1'b1;
    seq_b[10] = 1'b1;
    busy_cnt_b = 0;
    din_b = wb; dv_b = 1'b1;
    @(negedge clk);
    dv_b = 1'b0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      check("t2_txd", {31'd0, txd_b}, {31'd0, seq_b[k/4]});
    end
    @(negedge clk);
    check("t2_idle_busy", {31'd0, busy_b}, 32'd0);
    check("t2_idle_txd", {31'd0, txd_b}, 32'd1);
    check("t2_busy_len", busy_cnt_b, 32'd44);

    // 3: back-to-back frames
    starts.delete();
    busy_cnt_c = 0;
    push_c(8'h55);
    push_c(8'h0F);
    push_c(8'hFF);
    push_c(8'h00);
    wait_idle_c(1000);
    check("t3_busy_len", busy_cnt_c, 32'd160);
    check("t3_frames", starts.size(), 32'd4);
    for (int i = 1; i < starts.size(); i++)
      check("t3_gap", starts[i] - starts[i-1], 32'd40);
    check("t3_sb_empty", sb.size(), 32'd0);

    // 4: hold valid with incrementing data
    val = 8'h10; din_c = val; dv_c = 1'b1;
    prev = cnt_c; maxc = 3'd0; pops = 0;
    for (int k = 0; k < 200; k++) begin
      rdy = rdy_c;
      if (rdy) sb.push_back(val);
      @(negedge clk);
      if (rdy) begin
        val  = val + 8'd1;
        din_c = val;
      end
      check("t4_ready_vs_count", {31'd0, rdy_c}, {31'd0, cnt_c != 3'd4});
      if (prev == 3'd4 && cnt_c == 3'd3) begin
        check("t4_ready_after_pop", {31'd0, rdy_c}, 32'd1);
        pops++;
      end
      if (cnt_c > maxc) maxc = cnt_c;
      prev = cnt_c;
    end
    dv_c = 1'b0;
    check("t4_max_count", {29'd0, maxc}, 32'd4);
    check("t4_pops_seen", pops >= 2, 32'd1);
    wait_idle_c(1000);
    check("t4_sb_empty", sb.size(), 32'd0);

    // 5: reset mid-frame with two words queued
    push_c(8'hA0);
    push_c(8'hA1);
    push_c(8'hA2);
    repeat (8) @(negedge clk);
    check("t5_queued", {29'd0, cnt_c}, 32'd2);
    nstart = starts.size();
    rst_c = 1'b1;
    abort_c = 1'b1;
    sb.delete();
    @(negedge clk);
    rst_c = 1'b0;
    check("t5_txd", {31'd0, txd_c}, 32'd1);
    check("t5_busy", {31'd0, busy_c}, 32'd0);
    check("t5_cnt", {29'd0, cnt_c}, 32'd0);
    check("t5_rdy", {31'd0, rdy_c}, 32'd1);
    noisy = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (txd_c !== 1'b1 || busy_c !== 1'b0) noisy = 1'b1;
    end
    check("t5_quiet", {31'd0, noisy}, 32'd0);
    check("t5_no_new_frames", starts.size(), nstart);

    // 6: push on the same edge as the frame-end pop
    push_c(8'hB0);
    push_c(8'hB1);
    push_c(8'hB2);
    repeat (38) @(negedge clk);
    check("t6_cnt_before", {29'd0, cnt_c}, 32'd2);
    check("t6_last_stop", {31'd0, txd_c}, 32'd1);
    push_c(8'hB3);
    check("t6_cnt_after", {29'd0, cnt_c}, 32'd2);
    check("t6_next_start", {31'd0, txd_c}, 32'd0);
    wait_idle_c(1000);
    check("t6_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
